// File: rtl/rename_stage.sv
// rename_stage: in-order register renaming for up to WIDTH micro-ops per cycle.
//
// Holds the speculative RAT, the committed RAT, the physical free list and the
// per-physical-register ready bitmap.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_*                decoded group (lane 0 oldest); in_accept is the
//                       combinational, prefix-shaped consume mask
//   out_*               registered renamed group; out_ready takes the group
//   cmplt_valid/phys    completion broadcasts (ready bit set next cycle)
//   commit_*            in-order retirement; old mapping freed next cycle
//   flush               restore speculative state from the committed RAT
//   free_count          registered popcount of the free list
module rename_stage #(
    parameter int WIDTH     = 4,
    parameter int ARCH_REGS = 10,
    parameter int ARCH_W    = 4,
    parameter int PHYS_REGS = 32,
    parameter int PR_ADDR_W = 5,
    parameter int CMPLT_W   = 6,
    parameter int COMMIT_W  = 4,
    parameter int PAYLOAD_W = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in_valid,
    input  logic [WIDTH-1:0]              in_dst_en,
    input  logic [WIDTH*ARCH_W-1:0]       in_dst_arch,
    input  logic [WIDTH*ARCH_W-1:0]       in_src0_arch,
    input  logic [WIDTH*ARCH_W-1:0]       in_src1_arch,
    input  logic [WIDTH*PAYLOAD_W-1:0]    in_payload,
    output logic [WIDTH-1:0]              in_accept,
    output logic [WIDTH-1:0]              out_valid,
    input  logic                          out_ready,
    output logic [WIDTH*PR_ADDR_W-1:0]    out_dst_phys,
    output logic [WIDTH*PR_ADDR_W-1:0]    out_old_phys,
    output logic [WIDTH*PR_ADDR_W-1:0]    out_src0_phys,
    output logic [WIDTH*PR_ADDR_W-1:0]    out_src1_phys,
    output logic [WIDTH-1:0]              out_src0_rdy,
    output logic [WIDTH-1:0]              out_src1_rdy,
    output logic [WIDTH*PAYLOAD_W-1:0]    out_payload,
    input  logic [CMPLT_W-1:0]            cmplt_valid,
    input  logic [CMPLT_W*PR_ADDR_W-1:0]  cmplt_phys,
    input  logic [COMMIT_W-1:0]           commit_valid,
    input  logic [COMMIT_W*ARCH_W-1:0]    commit_arch,
    input  logic [COMMIT_W*PR_ADDR_W-1:0] commit_new_phys,
    input  logic [COMMIT_W*PR_ADDR_W-1:0] commit_old_phys,
    input  logic                          flush,
    output logic [PR_ADDR_W:0]            free_count
);

    // Registers ARCH_REGS and above start free; the identity mappings are ready.
    localparam logic [PHYS_REGS-1:0] FREE_INIT = {PHYS_REGS{1'b1}} << ARCH_REGS;

    logic [PR_ADDR_W-1:0] spec_rat [ARCH_REGS];
    logic [PR_ADDR_W-1:0] com_rat  [ARCH_REGS];
    logic [PR_ADDR_W-1:0] rat_tmp  [ARCH_REGS];
    logic [PR_ADDR_W-1:0] com_nxt  [ARCH_REGS];
    logic [PHYS_REGS-1:0] free_q, ready_q, free_tmp, alloc_mask, cmplt_mask;
    logic [PHYS_REGS-1:0] commit_mask, ref_mask, free_nxt, ready_nxt;
    logic [ARCH_REGS-1:0] grp_wr;
    logic [PR_ADDR_W:0]   cnt_nxt;
    logic                 can_load, open, found;
    logic [PR_ADDR_W-1:0] pick, s0_p, s1_p;
    logic [ARCH_W-1:0]    dst_a, s0_a, s1_a;
    logic [WIDTH*PR_ADDR_W-1:0] nxt_dst, nxt_old, nxt_s0, nxt_s1;
    logic [WIDTH-1:0]           nxt_r0, nxt_r1;

    always_comb begin
        cmplt_mask = '0;
        for (int c = 0; c < CMPLT_W; c++)
            if (cmplt_valid[c]) cmplt_mask[cmplt_phys[c*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
    end

    // Lane-serial rename: each lane sees the mappings written by earlier
    // accepted lanes through rat_tmp, and grp_wr marks those as not ready.
    always_comb begin
        can_load   = ~|out_valid | out_ready;
        open       = can_load & ~flush;
        free_tmp   = free_q;
        alloc_mask = '0;
        grp_wr     = '0;
        in_accept  = '0;
        nxt_dst    = '0;
        nxt_old    = '0;
        nxt_s0     = '0;
        nxt_s1     = '0;
        nxt_r0     = '0;
        nxt_r1     = '0;
        found      = 1'b0;
        pick       = '0;
        dst_a      = '0;
        s0_a       = '0;
        s1_a       = '0;
        s0_p       = '0;
        s1_p       = '0;
        for (int a = 0; a < ARCH_REGS; a++) rat_tmp[a] = spec_rat[a];
        for (int i = 0; i < WIDTH; i++) begin
            dst_a = in_dst_arch[i*ARCH_W +: ARCH_W];
            s0_a  = in_src0_arch[i*ARCH_W +: ARCH_W];
            s1_a  = in_src1_arch[i*ARCH_W +: ARCH_W];
            // lowest-numbered register still free after earlier lanes
            found = 1'b0;
            pick  = '0;
            for (int p = PHYS_REGS-1; p >= 0; p--)
                if (free_tmp[p]) begin
                    found = 1'b1;
                    pick  = PR_ADDR_W'(p);
                end
            s0_p = rat_tmp[s0_a];
            s1_p = rat_tmp[s1_a];
            nxt_s0[i*PR_ADDR_W +: PR_ADDR_W]  = s0_p;
            nxt_s1[i*PR_ADDR_W +: PR_ADDR_W]  = s1_p;
            nxt_r0[i] = ~grp_wr[s0_a] & (ready_q[s0_p] | cmplt_mask[s0_p]);
            nxt_r1[i] = ~grp_wr[s1_a] & (ready_q[s1_p] | cmplt_mask[s1_p]);
            nxt_old[i*PR_ADDR_W +: PR_ADDR_W] = rat_tmp[dst_a];
            if (in_dst_en[i]) nxt_dst[i*PR_ADDR_W +: PR_ADDR_W] = pick;
            if (open && in_valid[i] && (!in_dst_en[i] || found)) begin
                in_accept[i] = 1'b1;
                if (in_dst_en[i]) begin
                    free_tmp[pick]   = 1'b0;
                    alloc_mask[pick] = 1'b1;
                    rat_tmp[dst_a]   = pick;
                    grp_wr[dst_a]    = 1'b1;
                end
            end else begin
                open = 1'b0;  // a stalled lane blocks all younger lanes
            end
        end
    end

    // Commit, flush recovery and next free/ready state.
    always_comb begin
        commit_mask = '0;
        ref_mask    = '0;
        for (int a = 0; a < ARCH_REGS; a++) com_nxt[a] = com_rat[a];
        for (int j = 0; j < COMMIT_W; j++)
            if (commit_valid[j]) begin
                com_nxt[commit_arch[j*ARCH_W +: ARCH_W]] = commit_new_phys[j*PR_ADDR_W +: PR_ADDR_W];
                commit_mask[commit_old_phys[j*PR_ADDR_W +: PR_ADDR_W]] = 1'b1;
            end
        for (int a = 0; a < ARCH_REGS; a++) ref_mask[com_nxt[a]] = 1'b1;
        if (flush) begin
            free_nxt  = ~ref_mask;
            ready_nxt = ready_q | ref_mask;  // completions this cycle are dropped
        end else begin
            free_nxt  = (free_q & ~alloc_mask) | commit_mask;
            ready_nxt = (ready_q | cmplt_mask) & ~alloc_mask;
        end
        cnt_nxt = '0;
        for (int p = 0; p < PHYS_REGS; p++) cnt_nxt = cnt_nxt + (PR_ADDR_W+1)'(free_nxt[p]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                spec_rat[a] <= PR_ADDR_W'(a);
                com_rat[a]  <= PR_ADDR_W'(a);
            end
            free_q        <= FREE_INIT;
            ready_q       <= ~FREE_INIT;
            free_count    <= (PR_ADDR_W+1)'(PHYS_REGS - ARCH_REGS);
            out_valid     <= '0;
            out_dst_phys  <= '0;
            out_old_phys  <= '0;
            out_src0_phys <= '0;
            out_src1_phys <= '0;
            out_src0_rdy  <= '0;
            out_src1_rdy  <= '0;
            out_payload   <= '0;
        end else begin
            for (int a = 0; a < ARCH_REGS; a++) begin
                spec_rat[a] <= flush ? com_nxt[a] : rat_tmp[a];
                com_rat[a]  <= com_nxt[a];
            end
            free_q     <= free_nxt;
            ready_q    <= ready_nxt;
            free_count <= cnt_nxt;
            if (flush) begin
                out_valid <= '0;
            end else if (can_load) begin
                out_valid     <= in_accept;
                out_dst_phys  <= nxt_dst;
                out_old_phys  <= nxt_old;
                out_src0_phys <= nxt_s0;
                out_src1_phys <= nxt_s1;
                out_src0_rdy  <= nxt_r0;
                out_src1_rdy  <= nxt_r1;
                out_payload   <= in_payload;
            end
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed and randomized checks of rename_stage against a
// behavioural model (free list as an ordered list, RATs as int arrays, an
// in-order ROB queue feeding commits and completions).
module tb_rename_stage;
    localparam int W = 4, AR = 10, AW = 4, PR = 32, PW = 5, CW = 6, MW = 4, PLW = 12;

    logic clk = 1'b0, rst = 1'b0;
    logic [W-1:0]     in_valid, in_dst_en, in_accept, out_valid, out_src0_rdy, out_src1_rdy;
    logic [W*AW-1:0]  in_dst_arch, in_src0_arch, in_src1_arch;
    logic [W*PLW-1:0] in_payload, out_payload;
    logic             out_ready, flush;
    logic [W*PW-1:0]  out_dst_phys, out_old_phys, out_src0_phys, out_src1_phys;
    logic [CW-1:0]    cmplt_valid;
    logic [CW*PW-1:0] cmplt_phys;
    logic [MW-1:0]    commit_valid;
    logic [MW*AW-1:0] commit_arch;
    logic [MW*PW-1:0] commit_new_phys, commit_old_phys;
    logic [PW:0]      free_count;

    rename_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_dst_en(in_dst_en),
        .in_dst_arch(in_dst_arch), .in_src0_arch(in_src0_arch), .in_src1_arch(in_src1_arch),
        .in_payload(in_payload), .in_accept(in_accept), .out_valid(out_valid),
        .out_ready(out_ready), .out_dst_phys(out_dst_phys), .out_old_phys(out_old_phys),
        .out_src0_phys(out_src0_phys), .out_src1_phys(out_src1_phys),
        .out_src0_rdy(out_src0_rdy), .out_src1_rdy(out_src1_rdy), .out_payload(out_payload),
        .cmplt_valid(cmplt_valid), .cmplt_phys(cmplt_phys), .commit_valid(commit_valid),
        .commit_arch(commit_arch), .commit_new_phys(commit_new_phys),
        .commit_old_phys(commit_old_phys), .flush(flush), .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {bit de; int arch, dst, old, s0, s1; bit r0, r1; int pl;} lane_t;
    typedef struct {int arch, nw, old;} rob_t;

    int       m_spec [AR];
    int       m_com  [AR];
    bit       m_free [PR];
    bit       m_ready[PR];
    bit [W-1:0] m_ov;
    lane_t    m_out  [W];
    int       m_fc;
    rob_t     rob[$];
    int       checks = 0, failures = 0;
    logic [W-1:0] dut_acc;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < AR; a++) begin m_spec[a] = a; m_com[a] = a; end
        for (int p = 0; p < PR; p++) begin m_free[p] = (p >= AR); m_ready[p] = (p < AR); end
        m_ov = '0;
        m_fc = PR - AR;
        rob.delete();
    endtask

    task automatic idle();
        in_valid = '0; in_dst_en = '0; in_dst_arch = '0; in_src0_arch = '0; in_src1_arch = '0;
        in_payload = '0; out_ready = 1'b0; flush = 1'b0; cmplt_valid = '0; cmplt_phys = '0;
        commit_valid = '0; commit_arch = '0; commit_new_phys = '0; commit_old_phys = '0;
    endtask

    task automatic set_lane(int i, bit v, bit de, int d, int s0, int s1);
        in_valid[i] = v;
        in_dst_en[i] = de;
        in_dst_arch[i*AW +: AW]  = AW'(d);
        in_src0_arch[i*AW +: AW] = AW'(s0);
        in_src1_arch[i*AW +: AW] = AW'(s1);
        in_payload[i*PLW +: PLW] = PLW'($urandom);
    endtask

    // Retire the n oldest consumed micro-ops, in order, on ports 0..n-1.
    task automatic set_commits(int n);
        rob_t e;
        commit_valid = '0;
        for (int j = 0; j < n && j < MW && rob.size() > 0; j++) begin
            e = rob.pop_front();
            commit_valid[j] = 1'b1;
            commit_arch[j*AW +: AW]     = AW'(e.arch);
            commit_new_phys[j*PW +: PW] = PW'(e.nw);
            commit_old_phys[j*PW +: PW] = PW'(e.old);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a falling edge with inputs driven: check everything, advance
    // the model across the next rising edge, return at the next falling edge.
    task automatic step();
        bit [W-1:0] acc;
        lane_t nl[W];
        int n_spec[AR], n_com[AR], fl[$];
        bit n_free[PR], n_ready[PR], refd[PR], cm[PR], written[AR];
        bit blocked, can_load;
        int k, da, sa, sb, cnt;
        #1;
        dut_acc = in_accept;
        chk("out_valid", int'(out_valid), int'(m_ov));
        chk("free_count", int'(free_count), m_fc);
        for (int i = 0; i < W; i++) if (m_ov[i]) begin
            chk($sformatf("src0_phys[%0d]", i), int'(out_src0_phys[i*PW +: PW]), m_out[i].s0);
            chk($sformatf("src1_phys[%0d]", i), int'(out_src1_phys[i*PW +: PW]), m_out[i].s1);
            chk($sformatf("src0_rdy[%0d]", i), int'(out_src0_rdy[i]), int'(m_out[i].r0));
            chk($sformatf("src1_rdy[%0d]", i), int'(out_src1_rdy[i]), int'(m_out[i].r1));
            chk($sformatf("payload[%0d]", i), int'(out_payload[i*PLW +: PLW]), m_out[i].pl);
            if (m_out[i].de) begin
                chk($sformatf("dst_phys[%0d]", i), int'(out_dst_phys[i*PW +: PW]), m_out[i].dst);
                chk($sformatf("old_phys[%0d]", i), int'(out_old_phys[i*PW +: PW]), m_out[i].old);
            end
        end
        for (int p = 0; p < PR; p++) cm[p] = 1'b0;
        for (int c = 0; c < CW; c++) if (cmplt_valid[c]) cm[int'(cmplt_phys[c*PW +: PW])] = 1'b1;
        for (int p = 0; p < PR; p++) begin
            if (m_free[p]) fl.push_back(p);
            n_free[p]  = m_free[p];
            n_ready[p] = m_ready[p] | cm[p];
        end
        for (int a = 0; a < AR; a++) begin n_spec[a] = m_spec[a]; written[a] = 1'b0; end
        can_load = (m_ov == 0) || out_ready;
        blocked  = !can_load || flush;
        k   = 0;
        acc = '0;
        for (int i = 0; i < W; i++) nl[i] = m_out[i];
        for (int i = 0; i < W; i++) begin
            if (!blocked && in_valid[i] && (!in_dst_en[i] || k < fl.size())) begin
                acc[i] = 1'b1;
                da = int'(in_dst_arch[i*AW +: AW]);
                sa = int'(in_src0_arch[i*AW +: AW]);
                sb = int'(in_src1_arch[i*AW +: AW]);
                nl[i].de = in_dst_en[i];
                nl[i].pl = int'(in_payload[i*PLW +: PLW]);
                nl[i].s0 = n_spec[sa];
                nl[i].s1 = n_spec[sb];
                nl[i].r0 = written[sa] ? 1'b0 : (m_ready[nl[i].s0] | cm[nl[i].s0]);
                nl[i].r1 = written[sb] ? 1'b0 : (m_ready[nl[i].s1] | cm[nl[i].s1]);
                if (in_dst_en[i]) begin
                    nl[i].arch = da;
                    nl[i].old  = n_spec[da];
                    nl[i].dst  = fl[k];
                    n_spec[da] = fl[k];
                    written[da] = 1'b1;
                    n_free[fl[k]]  = 1'b0;
                    n_ready[fl[k]] = 1'b0;
                    k++;
                end
            end else begin
                blocked = 1'b1;
            end
        end
        chk("in_accept", int'(in_accept), int'(acc));
        for (int a = 0; a < AR; a++) n_com[a] = m_com[a];
        for (int j = 0; j < MW; j++) if (commit_valid[j]) begin
            n_com[int'(commit_arch[j*AW +: AW])] = int'(commit_new_phys[j*PW +: PW]);
            n_free[int'(commit_old_phys[j*PW +: PW])] = 1'b1;
        end
        if (flush) begin
            for (int p = 0; p < PR; p++) refd[p] = 1'b0;
            for (int a = 0; a < AR; a++) begin n_spec[a] = n_com[a]; refd[n_com[a]] = 1'b1; end
            for (int p = 0; p < PR; p++) begin n_free[p] = !refd[p]; n_ready[p] = m_ready[p] | refd[p]; end
        end
        @(posedge clk);
        if (flush) rob.delete();
        else if (out_ready)
            for (int i = 0; i < W; i++)
                if (m_ov[i] && m_out[i].de) rob.push_back('{m_out[i].arch, m_out[i].dst, m_out[i].old});
        m_spec = n_spec;
        m_com  = n_com;
        m_free = n_free;
        m_ready = n_ready;
        if (flush) m_ov = '0;
        else if (can_load) begin m_ov = acc; m_out = nl; end
        cnt = 0;
        for (int p = 0; p < PR; p++) cnt += int'(m_free[p]);
        m_fc = cnt;
        @(negedge clk);
    endtask

    task automatic rand_inputs(bit allow_commit);
        int cands[$];
        idle();
        for (int i = 0; i < W; i++)
            set_lane(i, ($urandom_range(0, 4) != 0), $urandom_range(0, 1) == 1,
                     $urandom_range(0, AR-1), $urandom_range(0, AR-1), $urandom_range(0, AR-1));
        out_ready = ($urandom_range(0, 3) != 0);
        foreach (rob[r]) cands.push_back(rob[r].nw);
        for (int i = 0; i < W; i++) if (m_ov[i] && m_out[i].de) cands.push_back(m_out[i].dst);
        for (int c = 0; c < CW; c++)
            if (cands.size() > 0 && $urandom_range(0, 2) == 0) begin
                cmplt_valid[c] = 1'b1;
                cmplt_phys[c*PW +: PW] = PW'(cands[$urandom_range(0, cands.size()-1)]);
            end
        if (allow_commit) set_commits($urandom_range(0, MW));
        flush = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        idle();
        #1;
        do_reset();
        chk("reset_free_count", int'(free_count), 22);
        chk("reset_out_valid", int'(out_valid), 0);

        // four destinations r1..r4 from reset
        idle(); out_ready = 1'b1;
        for (int i = 0; i < W; i++) set_lane(i, 1, 1, i+1, 0, 0);
        step();
        chk("t1_accept", int'(dut_acc), 4'b1111);
        for (int i = 0; i < W; i++) begin
            chk($sformatf("t1_dst[%0d]", i), int'(out_dst_phys[i*PW +: PW]), 10+i);
            chk($sformatf("t1_old[%0d]", i), int'(out_old_phys[i*PW +: PW]), 1+i);
        end
        chk("t1_free_count", int'(free_count), 18);

        // intra-group forwarding: lane0 writes r5, lane1 reads and rewrites r5
        idle(); out_ready = 1'b1;
        set_lane(0, 1, 1, 5, 0, 0);
        set_lane(1, 1, 1, 5, 5, 0);
        step();
        chk("fwd_src0_phys", int'(out_src0_phys[PW +: PW]), 14);
        chk("fwd_src0_rdy", int'(out_src0_rdy[1]), 0);
        chk("fwd_old_phys", int'(out_old_phys[PW +: PW]), 14);

        // back-pressure holds the group and blocks acceptance
        idle();
        for (int i = 0; i < W; i++) set_lane(i, 1, 1, 6+i, 1, 2);
        for (int n = 0; n < 5; n++) begin
            step();
            chk("stall_accept", int'(dut_acc), 0);
        end
        out_ready = 1'b1;
        step();
        chk("stall_release_accept", int'(dut_acc), 4'b1111);

        // completion bypass, then bitmap
        idle(); out_ready = 1'b1;
        set_lane(0, 1, 1, 1, 0, 0);
        step();
        idle(); out_ready = 1'b1;
        set_lane(0, 1, 0, 0, 1, 0);
        cmplt_valid[0] = 1'b1; cmplt_phys[0 +: PW] = PW'(20);
        step();
        chk("bypass_src0_phys", int'(out_src0_phys[0 +: PW]), 20);
        chk("bypass_src0_rdy", int'(out_src0_rdy[0]), 1);
        idle(); out_ready = 1'b1;
        set_lane(0, 1, 0, 0, 1, 0);
        step();
        chk("bitmap_src0_rdy", int'(out_src0_rdy[0]), 1);

        // drain the free list down to two registers without commits
        for (int n = 0; n < 20 && m_fc > 2; n++) begin
            idle(); out_ready = 1'b1;
            for (int i = 0; i < W && i < m_fc-2; i++)
                set_lane(i, 1, 1, $urandom_range(0, AR-1), $urandom_range(0, AR-1), 0);
            step();
        end
        chk("fill_free_count", int'(free_count), 2);
        idle(); out_ready = 1'b1;
        for (int i = 0; i < W; i++) set_lane(i, 1, 1, 7, 3, 4);
        step();
        chk("two_free_accept", int'(dut_acc), 4'b0011);
        idle(); out_ready = 1'b1;
        set_lane(0, 1, 0, 0, 2, 3);
        set_lane(1, 1, 1, 8, 2, 3);
        set_lane(2, 1, 0, 0, 2, 3);
        set_lane(3, 1, 0, 0, 2, 3);
        step();
        chk("empty_accept", int'(dut_acc), 4'b0001);
        // commit r1 (new 10, old 1): phys 1 is not allocatable this cycle
        idle(); out_ready = 1'b1;
        for (int i = 0; i < W; i++) set_lane(i, 1, 1, 9, 0, 0);
        set_commits(1);
        step();
        chk("same_cycle_free_accept", int'(dut_acc), 0);
        idle(); out_ready = 1'b1;
        for (int i = 0; i < W; i++) set_lane(i, 1, 1, 9, 0, 0);
        step();
        chk("next_cycle_free_accept", int'(dut_acc), 4'b0001);
        chk("next_cycle_free_dst", int'(out_dst_phys[0 +: PW]), 1);

        // flush recovery: three renames, commit r1->10, flush
        do_reset();
        idle(); out_ready = 1'b1;
        for (int i = 0; i < 3; i++) set_lane(i, 1, 1, i+1, 0, 0);
        step();
        idle(); out_ready = 1'b1;
        step();
        idle(); out_ready = 1'b1;
        set_commits(1);
        step();
        idle(); out_ready = 1'b1; flush = 1'b1;
        set_lane(0, 1, 0, 0, 1, 2);
        step();
        chk("flush_accept", int'(dut_acc), 0);
        chk("flush_out_valid", int'(out_valid), 0);
        idle(); out_ready = 1'b1;
        set_lane(0, 1, 0, 0, 1, 2);
        step();
        chk("flush_src0_phys", int'(out_src0_phys[0 +: PW]), 10);
        chk("flush_src0_rdy", int'(out_src0_rdy[0]), 1);
        chk("flush_src1_phys", int'(out_src1_phys[0 +: PW]), 2);

        // randomized traffic with commit-free stretches and a mid-run reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            rand_inputs((cyc % 400) < 280);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
